// File: rtl/stage_sequencer_pkg.sv
// Shared types and helpers for the stage sequencer: FSM state encoding,
// LFSR feedback taps and the thermometer-to-length conversion.
package stage_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_CLEAR,
    ST_ALLCLEAR,
    ST_FAIL
  } state_t;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic int unsigned therm_len(input logic [31:0] mask);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(mask[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Game-control bus between the input conditioning, the sequencer and the display.
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 5,
  parameter int BTN_W      = 2
) ();
  logic                  tick;
  logic                  start;
  logic                  btn_valid;
  logic [BTN_W-1:0]      btn_code;
  logic [NUM_STAGES-1:0] stage;
  logic                  show_valid;
  logic [BTN_W-1:0]      show_code;
  logic                  input_en;
  logic                  clear;
  logic                  allclear;
  logic                  fail;
  logic                  busy;

  modport master (
    output tick, start, btn_valid, btn_code,
    input  stage, show_valid, show_code, input_en, clear, allclear, fail, busy
  );

  modport slave (
    input  tick, start, btn_valid, btn_code,
    output stage, show_valid, show_code, input_en, clear, allclear, fail, busy
  );
endinterface

// File: rtl/stage_sequencer_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the sequence source.
module lfsr8
  import stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= seed;
    end else begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Memory-game controller: loads a random sequence, shows a growing prefix of it
// each stage, checks the player's presses and reports clear/allclear/fail.
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int         NUM_STAGES    = 5,
  parameter int         BTN_W         = 2,
  parameter int         SHOW_TICKS    = 4,
  parameter int         TIMEOUT_TICKS = 32,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input logic              clk,
  input logic              reset,
  stage_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_STAGES + 1);
  localparam int SHW_W = $clog2(SHOW_TICKS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] FULL_LEN  = CNT_W'(NUM_STAGES);
  localparam logic [SHW_W-1:0] SHOW_LAST = SHW_W'(SHOW_TICKS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);

  state_t                state_reg;
  logic [NUM_STAGES-1:0] stage_reg;
  logic                  show_valid_reg;
  logic [BTN_W-1:0]      show_code_reg;
  logic                  input_en_reg;
  logic                  clear_reg;
  logic                  allclear_reg;
  logic                  fail_reg;
  logic                  busy_reg;
  logic [CNT_W-1:0]      idx_reg;
  logic [CNT_W-1:0]      ptr_reg;
  logic [SHW_W-1:0]      show_cnt_reg;
  logic [TMO_W-1:0]      tmo_reg;

  logic [7:0]            lfsr_q;
  logic                  lfsr_unused;
  logic [BTN_W-1:0]      seq_words [NUM_STAGES];
  logic [CNT_W-1:0]      len;
  logic [CNT_W-1:0]      last_ptr;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[7:BTN_W];

  // One register per sequence step; entry gi is captured on LOAD cycle gi
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_seq
      logic [BTN_W-1:0] entry_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (state_reg == ST_LOAD && idx_reg == CNT_W'(gi)) begin
          entry_reg <= lfsr_q[BTN_W-1:0];
        end
      end
      assign seq_words[gi] = entry_reg;
    end
  endgenerate

  assign len      = CNT_W'(therm_len(32'(stage_reg)));
  assign last_ptr = len - 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      stage_reg      <= '0;
      show_valid_reg <= 1'b0;
      show_code_reg  <= '0;
      input_en_reg   <= 1'b0;
      clear_reg      <= 1'b0;
      allclear_reg   <= 1'b0;
      fail_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      idx_reg        <= '0;
      ptr_reg        <= '0;
      show_cnt_reg   <= '0;
      tmo_reg        <= '0;
    end else begin
      clear_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_FAIL, ST_ALLCLEAR: begin
          if (bus.start) begin
            state_reg    <= ST_LOAD;
            stage_reg    <= NUM_STAGES'(1);
            fail_reg     <= 1'b0;
            allclear_reg <= 1'b0;
            busy_reg     <= 1'b1;
            idx_reg      <= '0;
          end
        end
        ST_LOAD: begin
          if (idx_reg == LAST_IDX) begin
            state_reg      <= ST_SHOW_ON;
            ptr_reg        <= '0;
            show_cnt_reg   <= '0;
            show_valid_reg <= 1'b1;
            // a one-entry sequence is still being written this cycle
            show_code_reg  <= (LAST_IDX == '0) ? lfsr_q[BTN_W-1:0] : seq_words[0];
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_SHOW_ON: begin
          if (bus.tick) begin
            if (show_cnt_reg == SHOW_LAST) begin
              state_reg      <= ST_SHOW_OFF;
              show_valid_reg <= 1'b0;
              show_cnt_reg   <= '0;
            end else begin
              show_cnt_reg <= show_cnt_reg + 1'b1;
            end
          end
        end
        ST_SHOW_OFF: begin
          if (bus.tick) begin
            if (ptr_reg == last_ptr) begin
              state_reg    <= ST_WAIT_IN;
              ptr_reg      <= '0;
              tmo_reg      <= '0;
              input_en_reg <= 1'b1;
            end else begin
              state_reg      <= ST_SHOW_ON;
              ptr_reg        <= ptr_reg + 1'b1;
              show_valid_reg <= 1'b1;
              show_code_reg  <= seq_words[ptr_reg + 1'b1];
            end
          end
        end
        ST_WAIT_IN: begin
          // a press always takes priority over a coincident tick
          if (bus.btn_valid) begin
            if (bus.btn_code == seq_words[ptr_reg]) begin
              tmo_reg <= '0;
              if (ptr_reg == last_ptr) begin
                state_reg    <= ST_CLEAR;
                input_en_reg <= 1'b0;
                clear_reg    <= (len != FULL_LEN);
              end else begin
                ptr_reg <= ptr_reg + 1'b1;
              end
            end else begin
              state_reg    <= ST_FAIL;
              fail_reg     <= 1'b1;
              input_en_reg <= 1'b0;
              busy_reg     <= 1'b0;
            end
          end else if (bus.tick) begin
            if (tmo_reg == TMO_LAST) begin
              state_reg    <= ST_FAIL;
              fail_reg     <= 1'b1;
              input_en_reg <= 1'b0;
              busy_reg     <= 1'b0;
            end else begin
              tmo_reg <= tmo_reg + 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (len == FULL_LEN) begin
            state_reg    <= ST_ALLCLEAR;
            allclear_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end else begin
            state_reg      <= ST_SHOW_ON;
            stage_reg      <= NUM_STAGES'({stage_reg, 1'b1});
            ptr_reg        <= '0;
            show_cnt_reg   <= '0;
            show_valid_reg <= 1'b1;
            show_code_reg  <= seq_words[0];
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.stage      = stage_reg;
  assign bus.show_valid = show_valid_reg;
  assign bus.show_code  = show_code_reg;
  assign bus.input_en   = input_en_reg;
  assign bus.clear      = clear_reg;
  assign bus.allclear   = allclear_reg;
  assign bus.fail       = fail_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: LFSR reference model, show_code scoreboard and a
// per-stage expectation table, plus directed reset/timeout/fail sequences.
module tb_stage_sequencer;

  localparam int N = 5;

  typedef struct {
    int         presses;
    logic [4:0] exp_stage;
    logic       exp_clear;
    logic       exp_allclear;
  } stage_vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stage_sequencer_if #(.NUM_STAGES(N), .BTN_W(2)) bus ();

  stage_sequencer #(
    .NUM_STAGES   (N),
    .BTN_W        (2),
    .SHOW_TICKS   (4),
    .TIMEOUT_TICKS(32),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_lfsr;
  logic [1:0] seq [N];
  logic [1:0] exp_q [$];
  logic       prev_sv = 1'b0;
  stage_vec_t tbl [5];

  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] therm(input int k);
    return 5'((1 << k) - 1);
  endfunction

  // scoreboard: each new display step pops the next expected code
  always @(negedge clk) begin
    if (bus.show_valid && !prev_sv) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL show_unexpected: got %0d, expected no display", bus.show_code);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        $display("show code=%0d expected=%0d", bus.show_code, e);
        check("show_code", 32'(bus.show_code), 32'(e));
      end
    end
    prev_sv <= bus.show_valid;
  end

  task automatic step(input logic t, input logic s, input logic bv, input logic [1:0] bc);
    bus.tick = t;
    bus.start = s;
    bus.btn_valid = bv;
    bus.btn_code = bc;
    @(negedge clk);
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.btn_valid = 1'b0;
  endtask

  task automatic push_prefix(input int k);
    for (int j = 0; j < k; j++) exp_q.push_back(seq[j]);
  endtask

  task automatic do_start();
    step(0, 1, 0, 2'd0);
    check("start_stage", 32'(bus.stage), 32'(5'b00001));
    check("start_fail", 32'(bus.fail), 0);
    check("start_allclear", 32'(bus.allclear), 0);
    check("start_busy", 32'(bus.busy), 1);
    for (int i = 0; i < N; i++) begin
      seq[i] = m_lfsr[1:0];
      if (i < N - 1) step(0, 0, 0, 2'd0);
    end
    $display("start seq=%0d %0d %0d %0d %0d", seq[0], seq[1], seq[2], seq[3], seq[4]);
    push_prefix(1);
  endtask

  task automatic wait_input_en(input bit noise);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.input_en) begin
        got = 1'b1;
        break;
      end
      step(1'(c % 2), 0, noise && bus.show_valid, 2'($urandom_range(0, 3)));
    end
    check("input_en_reached", 32'(got), 1);
    check("show_all_seen", exp_q.size(), 0);
    check("no_fail_in_show", 32'(bus.fail), 0);
  endtask

  task automatic press(input logic [1:0] code, input logic t);
    $display("press code=%0d tick=%0d", code, t);
    step(t, 0, 1, code);
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.btn_valid = 1'b0;
    bus.btn_code = 2'd0;
    tbl[0] = '{1, 5'b00011, 1'b1, 1'b0};
    tbl[1] = '{2, 5'b00111, 1'b1, 1'b0};
    tbl[2] = '{3, 5'b01111, 1'b1, 1'b0};
    tbl[3] = '{4, 5'b11111, 1'b1, 1'b0};
    tbl[4] = '{5, 5'b11111, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_stage", 32'(bus.stage), 0);
    check("rst_show_valid", 32'(bus.show_valid), 0);
    check("rst_input_en", 32'(bus.input_en), 0);
    check("rst_flags", {29'd0, bus.clear, bus.allclear, bus.fail}, 0);
    check("rst_busy", 32'(bus.busy), 0);

    // reset in the middle of a display step
    do_start();
    for (int c = 0; c < 20 && !bus.show_valid; c++) step(0, 0, 0, 2'd0);
    check("show_seen_before_reset", 32'(bus.show_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_show_valid", 32'(bus.show_valid), 0);
    check("midrst_stage", 32'(bus.stage), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_flags", {28'd0, bus.clear, bus.allclear, bus.fail, bus.input_en}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 12; c++) step(1'(c % 2), 0, 1, 2'd0);
    check("idle_after_reset_busy", 32'(bus.busy), 0);
    check("idle_after_reset_stage", 32'(bus.stage), 0);

    // full game, with ignored press noise and an ignored start at stage 3
    do_start();
    for (int e = 0; e < 5; e++) begin
      int k;
      k = tbl[e].presses;
      wait_input_en(k == 3);
      if (k == 3) begin
        step(0, 1, 0, 2'd0);
        check("start_ignored_input_en", 32'(bus.input_en), 1);
        check("start_ignored_busy", 32'(bus.busy), 1);
      end
      check("stage_before", 32'(bus.stage), 32'(therm(k)));
      for (int j = 0; j < k; j++) press(seq[j], 1'b0);
      check("clear_pulse", 32'(bus.clear), 32'(tbl[e].exp_clear));
      check("input_en_off", 32'(bus.input_en), 0);
      if (tbl[e].exp_clear) push_prefix(k + 1);
      step(0, 0, 0, 2'd0);
      check("stage_after", 32'(bus.stage), 32'(tbl[e].exp_stage));
      check("clear_one_cycle", 32'(bus.clear), 0);
      check("allclear", 32'(bus.allclear), 32'(tbl[e].exp_allclear));
      check("busy_after", 32'(bus.busy), 32'(!tbl[e].exp_allclear));
    end

    // wrong code on step 2 of stage 2
    do_start();
    wait_input_en(0);
    press(seq[0], 1'b0);
    push_prefix(2);
    step(0, 0, 0, 2'd0);
    wait_input_en(0);
    press(seq[0], 1'b0);
    press(seq[1] ^ 2'b01, 1'b0);
    check("wrong_fail", 32'(bus.fail), 1);
    check("wrong_stage", 32'(bus.stage), 32'(5'b00011));
    check("wrong_input_en", 32'(bus.input_en), 0);
    check("wrong_busy", 32'(bus.busy), 0);
    check("wrong_clear", 32'(bus.clear), 0);

    // restart from FAIL, then timeout behaviour in stage 2
    do_start();
    wait_input_en(0);
    press(seq[0], 1'b0);
    push_prefix(2);
    step(0, 0, 0, 2'd0);
    wait_input_en(0);
    repeat (30) step(1, 0, 0, 2'd0);
    check("tmo30_fail", 32'(bus.fail), 0);
    press(seq[0], 1'b1);
    check("tmo_press_input_en", 32'(bus.input_en), 1);
    check("tmo_press_fail", 32'(bus.fail), 0);
    repeat (31) step(1, 0, 0, 2'd0);
    check("tmo31_fail", 32'(bus.fail), 0);
    check("tmo31_input_en", 32'(bus.input_en), 1);
    step(1, 0, 0, 2'd0);
    check("tmo32_fail", 32'(bus.fail), 1);
    check("tmo32_stage", 32'(bus.stage), 32'(5'b00011));
    check("tmo32_input_en", 32'(bus.input_en), 0);
    check("tmo32_busy", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
